branch_rs: RTL and testbench
============================

// Module: branch_rs
// PURPOSE
//  Reservation station and issue scheduler for the branch unit. Holds dispatched branch ops
//  (jz/jnz/jgt/jlt) until their target (vt) and operands (va, vb) are resolved. Captures
//  missing operands from the CDB and issues at most one ready op per cycle, oldest first.
//  Sits between dispatch/rename and the branch unit. The branch unit never stalls, so issue
//  has no back-pressure.
// PARAMETERS
//  DEPTH  4   number of RS entries (>=2)
//  W      16  operand/target value width
//  TW     4   ROB tag width (ROB index)
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous active-high reset
//  flush        in   1      mispredict flush: drop all entries and the issue register
//  disp_valid   in   1      dispatch request
//  disp_ready   out  1      RS can accept; transfer when disp_valid&disp_ready
//  disp_opcode  in   4      branch opcode, passed through unchanged
//  disp_rob     in   TW     ROB index of the branch
//  disp_vt      in   W      target value if disp_rt=1, else producer tag in [TW-1:0]
//  disp_rt      in   1      vt ready
//  disp_va      in   W      operand a value if disp_ra=1, else producer tag in [TW-1:0]
//  disp_ra      in   1      va ready
//  disp_vb      in   W      operand b value if disp_rb=1, else producer tag in [TW-1:0]
//  disp_rb      in   1      vb ready
//  cdb_valid    in   1      result broadcast valid
//  cdb_tag      in   TW     ROB tag of the broadcast result
//  cdb_value    in   W      broadcast result value
//  iss_valid    out  1      issue to branch unit (registered)
//  iss_opcode   out  4      issued opcode
//  iss_rob      out  TW     issued ROB index
//  iss_vt       out  W      issued target
//  iss_va       out  W      issued operand a
//  iss_vb       out  W      issued operand b
//  occupancy    out  $clog2(DEPTH+1)  valid entries (registered)
// BEHAVIOUR
//  - Reset: all entries invalid; occupancy=0; iss_valid=0; iss_* data=0; disp_ready=1.
//  - Storage is a collapsing, age-ordered queue. Entry 0 is the oldest; entries [0..occ-1] are valid.
//  - disp_ready = (occupancy != DEPTH), registered state only. A full RS refuses dispatch even
//    in a cycle where it issues.
//  - Wakeup: on cdb_valid, every valid entry with a not-ready field whose tag == cdb_tag
//    captures cdb_value and sets that field ready at the edge. Several fields of one entry may
//    wake in the same cycle.
//  - Dispatch/CDB same cycle: if an incoming not-ready field's tag == cdb_tag with cdb_valid=1,
//    the field is written as ready with cdb_value.
//  - Select (combinational on registered entries): the lowest-index entry with vt, va and vb
//    all ready. Fields woken this cycle are not eligible until the next cycle.
//  - Issue: at the edge, the selected entry is copied to iss_*, iss_valid=1, the entry is
//    removed and younger entries shift down one slot. If nothing is ready, iss_valid=0 and
//    iss_* data holds its previous value.
//  - Dispatch while issuing: the new op is written at slot occ-1 (after the shift), else at
//    slot occ. occupancy += dispatch - issue.
//  - Latency: an op dispatched ready in cycle t is visible at t+1 and has iss_valid at t+2.
//    A CDB wake in cycle t gives issue earliest at t+2.
//  - flush: at the edge, occupancy=0, all entries invalid, iss_valid=0. Dispatch and issue in
//    the same cycle are discarded. rst has priority over flush.
//  - No tag-width arithmetic; tag compares are equality on TW bits. occupancy never exceeds DEPTH.
// TESTING
//  1 rst, then dispatch jz rob=3 all-ready va=0 vt=0x0040 -> iss_valid two cycles later,
//    iss_rob=3, iss_vt=0x0040, iss_va=0.
//  2 dispatch rob=1 (va tag 5 not ready), then rob=2 all-ready -> rob=2 issues first. cdb tag=5
//    val=7 -> rob=1 issues two cycles later with iss_va=7.
//  3 dispatch with vb tag=6 while cdb_valid tag=6 val=0x1234 -> entry ready at once;
//    iss_vb=0x1234 at t+2.
//  4 fill 4 not-ready entries -> disp_ready=0, occupancy=4. Next dispatch not accepted. Wake
//    entry 2 -> issued, occupancy=3, order of rob 0,1,3 kept.
//  5 three entries held, flush with disp_valid=1 and one entry ready -> next cycle occupancy=0,
//    iss_valid=0, disp_ready=1.
//  6 rst asserted mid-operation with 2 entries and a pending issue -> all reset values next cycle.

Source files
------------

// File: rtl/branch_rs.sv
// rtl/branch_rs.sv - branch reservation station: collapsing age-ordered queue, CDB wakeup, oldest-ready issue
module branch_rs #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  parameter int TW    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [3:0]                   disp_opcode,
  input  logic [TW-1:0]                disp_rob,
  input  logic [W-1:0]                 disp_vt,
  input  logic                         disp_rt,
  input  logic [W-1:0]                 disp_va,
  input  logic                         disp_ra,
  input  logic [W-1:0]                 disp_vb,
  input  logic                         disp_rb,
  input  logic                         cdb_valid,
  input  logic [TW-1:0]                cdb_tag,
  input  logic [W-1:0]                 cdb_value,
  output logic                         iss_valid,
  output logic [3:0]                   iss_opcode,
  output logic [TW-1:0]                iss_rob,
  output logic [W-1:0]                 iss_vt,
  output logic [W-1:0]                 iss_va,
  output logic [W-1:0]                 iss_vb,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]    op;
    logic [TW-1:0] rob;
    logic [W-1:0]  vt;
    logic [W-1:0]  va;
    logic [W-1:0]  vb;
    logic          rt;
    logic          ra;
    logic          rb;
  } entry_t;

  // Not-ready fields hold the producer tag in their low TW bits.
  function automatic entry_t f_wake(input entry_t e, input logic v,
                                    input logic [TW-1:0] t, input logic [W-1:0] d);
    entry_t e_out;
    e_out = e;
    if (v && !e.rt && e.vt[TW-1:0] == t) begin e_out.vt = d; e_out.rt = 1'b1; end
    if (v && !e.ra && e.va[TW-1:0] == t) begin e_out.va = d; e_out.ra = 1'b1; end
    if (v && !e.rb && e.vb[TW-1:0] == t) begin e_out.vb = d; e_out.rb = 1'b1; end
    return e_out;
  endfunction

  entry_t          r_ent [DEPTH];
  logic [OW-1:0]   r_occ;
  logic            r_iss_valid;
  entry_t          r_iss;

  entry_t          w_nxt [DEPTH];
  entry_t          w_new;
  logic            w_sel_found;
  logic [IW-1:0]   w_sel_idx;
  logic            w_issue;
  logic            w_accept;
  logic [OW-1:0]   w_wr_pos;
  logic [OW-1:0]   w_occ_nxt;

  assign disp_ready = (r_occ != OW'(DEPTH));

  // Selection sees only registered readiness, so same-cycle wakeups wait a cycle.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (OW'(i) < r_occ && r_ent[i].rt && r_ent[i].ra && r_ent[i].rb) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IW'(i);
      end
    end
  end

  assign w_issue   = w_sel_found;
  assign w_accept  = disp_valid && disp_ready;
  assign w_wr_pos  = w_issue ? (r_occ - OW'(1)) : r_occ;
  assign w_occ_nxt = r_occ + OW'(w_accept) - OW'(w_issue);

  always_comb begin
    w_new = '{op: disp_opcode, rob: disp_rob, vt: disp_vt, va: disp_va, vb: disp_vb,
              rt: disp_rt, ra: disp_ra, rb: disp_rb};
    w_new = f_wake(w_new, cdb_valid, cdb_tag, cdb_value);
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = f_wake(r_ent[i], cdb_valid, cdb_tag, cdb_value);
    end
    if (w_issue) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        if (IW'(i) >= w_sel_idx) w_nxt[i] = f_wake(r_ent[i+1], cdb_valid, cdb_tag, cdb_value);
      end
    end
    if (w_accept) w_nxt[w_wr_pos[IW-1:0]] = w_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_occ       <= '0;
      r_iss_valid <= 1'b0;
      r_iss       <= '0;
    end else if (flush) begin
      r_occ       <= '0;
      r_iss_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_nxt[i];
      r_occ       <= w_occ_nxt;
      r_iss_valid <= w_issue;
      if (w_issue) r_iss <= r_ent[w_sel_idx];
    end
  end

  assign iss_valid  = r_iss_valid;
  assign iss_opcode = r_iss.op;
  assign iss_rob    = r_iss.rob;
  assign iss_vt     = r_iss.vt;
  assign iss_va     = r_iss.va;
  assign iss_vb     = r_iss.vb;
  assign occupancy  = r_occ;

endmodule

// File: tb/tb_branch_rs.sv
// tb/tb_branch_rs.sv - directed self-checking bench for branch_rs
module tb_branch_rs;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        disp_valid, disp_ready;
  logic [3:0]  disp_opcode;
  logic [3:0]  disp_rob;
  logic [15:0] disp_vt, disp_va, disp_vb;
  logic        disp_rt, disp_ra, disp_rb;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic        iss_valid;
  logic [3:0]  iss_opcode, iss_rob;
  logic [15:0] iss_vt, iss_va, iss_vb;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_rs #(.DEPTH(4), .W(16), .TW(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_opcode(disp_opcode),
    .disp_rob(disp_rob), .disp_vt(disp_vt), .disp_rt(disp_rt),
    .disp_va(disp_va), .disp_ra(disp_ra), .disp_vb(disp_vb), .disp_rb(disp_rb),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .iss_valid(iss_valid), .iss_opcode(iss_opcode), .iss_rob(iss_rob),
    .iss_vt(iss_vt), .iss_va(iss_va), .iss_vb(iss_vb), .occupancy(occupancy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] rob,
                      input logic [15:0] vt, input logic rt,
                      input logic [15:0] va, input logic ra,
                      input logic [15:0] vb, input logic rb);
    disp_valid = 1'b1; disp_opcode = op; disp_rob = rob;
    disp_vt = vt; disp_rt = rt; disp_va = va; disp_ra = ra; disp_vb = vb; disp_rb = rb;
  endtask

  task automatic idle();
    disp_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [15:0] val);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_value = val;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_opcode = '0; disp_rob = '0;
    disp_vt = '0; disp_va = '0; disp_vb = '0; disp_rt = 1'b0; disp_ra = 1'b0; disp_rb = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    #2;
    tick(); tick();
    rst = 1'b0;

    // 1: all-ready op issues two edges after dispatch
    check("rst_occ", occupancy, 0);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_iss_rob", iss_rob, 0);
    disp(4'h1, 4'd3, 16'h0040, 1, 16'h0000, 1, 16'h0000, 1);
    tick(); idle();
    check("t1_occ1", occupancy, 1);
    check("t1_no_iss_yet", iss_valid, 0);
    tick();
    check("t1_iss_valid", iss_valid, 1);
    check("t1_iss_rob", iss_rob, 3);
    check("t1_iss_vt", iss_vt, 16'h0040);
    check("t1_iss_va", iss_va, 0);
    check("t1_iss_op", iss_opcode, 1);
    check("t1_occ0", occupancy, 0);
    tick();
    check("t1_iss_drop", iss_valid, 0);
    check("t1_iss_hold", iss_rob, 3);

    // 2: younger ready op bypasses older waiting op; CDB wake issues at t+2
    disp(4'h2, 4'd1, 16'h0010, 1, 16'h0005, 0, 16'h0002, 1);
    tick();
    disp(4'h3, 4'd2, 16'h0020, 1, 16'h0009, 1, 16'h0008, 1);
    tick(); idle();
    check("t2_occ2", occupancy, 2);
    tick();
    check("t2_iss_valid_a", iss_valid, 1);
    check("t2_iss_rob_a", iss_rob, 2);
    check("t2_occ1", occupancy, 1);
    cdb(4'd5, 16'h0007);
    tick(); idle();
    check("t2_wake_not_yet", iss_valid, 0);
    tick();
    check("t2_iss_valid_b", iss_valid, 1);
    check("t2_iss_rob_b", iss_rob, 1);
    check("t2_iss_va_b", iss_va, 16'h0007);
    check("t2_iss_vt_b", iss_vt, 16'h0010);
    check("t2_occ0", occupancy, 0);

    // 3: dispatch-time CDB bypass
    disp(4'h4, 4'd4, 16'h0100, 1, 16'h0011, 1, 16'h0006, 0);
    cdb(4'd6, 16'h1234);
    tick(); idle();
    check("t3_occ1", occupancy, 1);
    tick();
    check("t3_iss_valid", iss_valid, 1);
    check("t3_iss_rob", iss_rob, 4);
    check("t3_iss_vb", iss_vb, 16'h1234);
    tick();

    // 4: full RS refuses dispatch; middle entry issues; shared-tag wake keeps age order
    disp(4'h1, 4'd0, 16'h0A00, 1, 16'h0008, 0, 16'h0008, 0); tick();
    disp(4'h1, 4'd1, 16'h0A01, 1, 16'h0008, 0, 16'h0001, 1); tick();
    disp(4'h1, 4'd2, 16'h0A02, 1, 16'h000A, 0, 16'h0002, 1); tick();
    disp(4'h1, 4'd3, 16'h0A03, 1, 16'h0008, 0, 16'h0003, 1); tick();
    check("t4_occ_full", occupancy, 4);
    check("t4_disp_ready_full", disp_ready, 0);
    disp(4'h5, 4'd5, 16'h0A05, 1, 16'h0000, 1, 16'h0000, 1);
    tick(); idle();
    check("t4_refused_occ", occupancy, 4);
    check("t4_refused_iss", iss_valid, 0);
    cdb(4'd10, 16'h0055);
    tick(); idle();
    tick();
    check("t4_iss2_valid", iss_valid, 1);
    check("t4_iss2_rob", iss_rob, 2);
    check("t4_iss2_va", iss_va, 16'h0055);
    check("t4_occ3", occupancy, 3);
    check("t4_ready_again", disp_ready, 1);
    cdb(4'd8, 16'h0077);
    tick(); idle();
    check("t4_wake_wait", iss_valid, 0);
    tick();
    check("t4_iss0_rob", iss_rob, 0);
    check("t4_iss0_va", iss_va, 16'h0077);
    check("t4_iss0_vb", iss_vb, 16'h0077);
    check("t4_occ2", occupancy, 2);
    tick();
    check("t4_iss1_rob", iss_rob, 1);
    check("t4_iss1_valid", iss_valid, 1);
    tick();
    check("t4_iss3_rob", iss_rob, 3);
    check("t4_iss3_vt", iss_vt, 16'h0A03);
    check("t4_occ0", occupancy, 0);
    tick();
    check("t4_idle", iss_valid, 0);
    check("t4_no_rob5", occupancy, 0);

    // 5: flush drops entries, concurrent dispatch and issue
    disp(4'h2, 4'd1, 16'h0001, 1, 16'h000C, 0, 16'h0000, 1); tick();
    disp(4'h2, 4'd2, 16'h0002, 1, 16'h000C, 0, 16'h0000, 1); tick();
    disp(4'h2, 4'd3, 16'h0003, 1, 16'h000C, 0, 16'h0000, 1); tick(); idle();
    cdb(4'd12, 16'h0099);
    tick(); idle();
    check("t5_occ3", occupancy, 3);
    flush = 1'b1;
    disp(4'h2, 4'd7, 16'h0007, 1, 16'h0000, 1, 16'h0000, 1);
    tick(); idle();
    check("t5_flush_occ", occupancy, 0);
    check("t5_flush_iss", iss_valid, 0);
    check("t5_flush_ready", disp_ready, 1);
    tick();
    check("t5_after_iss", iss_valid, 0);
    check("t5_after_occ", occupancy, 0);

    // 6: reset mid-operation with a pending issue
    disp(4'h3, 4'd7, 16'h0070, 1, 16'h000D, 0, 16'h0000, 1); tick();
    disp(4'h4, 4'd6, 16'h0060, 1, 16'h0001, 1, 16'h0002, 1); tick(); idle();
    check("t6_occ2", occupancy, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_occ", occupancy, 0);
    check("t6_rst_iss_valid", iss_valid, 0);
    check("t6_rst_iss_rob", iss_rob, 0);
    check("t6_rst_iss_vt", iss_vt, 0);
    check("t6_rst_ready", disp_ready, 1);
    tick();
    check("t6_post_iss", iss_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
